if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_pkg.sv | 26 ++
 rtl/if_fetch_ctl.sv | 123 ++++++++++++
 rtl/if_fetch.sv | 94 +++++++++
 tb/tb_if_fetch.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Optional feature macro: IF_MISALIGN_EN (misaligned-fetch exception path).
package if_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,   // request outstanding (or about to be issued)
      S_HOLD  = 2'd1,   // instruction buffered, waiting for IF/ID to take it
      S_DROP  = 2'd2    // redirected while a request was in flight; swallow its ack
   } state_t;

   localparam word_t DEF_RESET_PC  = 32'h0000_0000;
   localparam word_t DEF_NOP_INSTR = 32'h0000_0000;

   // Address as it is loaded into req_addr: word-aligned unless the
   // misaligned-fetch exception path is built in.
   function automatic word_t align_addr(input word_t a);
`ifdef IF_MISALIGN_EN
      return a;
`else
      return a & 32'hFFFF_FFFC;
`endif
   endfunction

endpackage

// File: rtl/if_fetch_ctl.sv
// Fetch control: state machine plus the pc / req_addr registers.
// Honours IF_MISALIGN_EN: when defined, a misaligned req_addr suppresses the
// memory request and raises a capture-exception strobe instead.
//
// Memory handshake: imem_req is a request valid, imem_ack a single-cycle
// completion. Once imem_req rises, imem_addr is held stable until the cycle in
// which imem_ack is seen; a request is never withdrawn except by RST.
module if_fetch_ctl
   import if_pkg::*;
#(
   parameter word_t RESET_PC = DEF_RESET_PC
) (
   input  logic   CLK,
   input  logic   RST,
   input  logic   stall,
   input  logic   redirect,
   input  word_t  redirect_pc,
   input  logic   imem_ack,
   output logic   imem_req,
   output word_t  imem_addr,
   output logic   if_write,
   output logic   cap_data,
   output logic   cap_exc,
   output logic   clr_valid,
   output word_t  cap_pc4
);

   state_t state_q, state_d;
   word_t  pc_q, pc_d;
   word_t  req_addr_q, req_addr_d;
   logic   misalign;
   logic   write_raw;

   // Misaligned request detection (only meaningful with the exception path built in)
   always_comb begin
`ifdef IF_MISALIGN_EN
      misalign = (req_addr_q[1:0] != 2'b00);
`else
      misalign = 1'b0;
`endif
   end

   assign cap_pc4   = req_addr_q + 32'd4;
   assign imem_addr = req_addr_q;
   // No request in HOLD, on a misaligned address, or while in reset
   assign imem_req  = (state_q != S_HOLD) && !misalign && !RST;
   assign if_write  = write_raw && !RST;

   // Next-state and register update logic; redirect wins over stall
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      write_raw  = 1'b0;
      cap_data   = 1'b0;
      cap_exc    = 1'b0;
      clr_valid  = 1'b0;

      if (redirect) begin
         pc_d      = redirect_pc;
         clr_valid = 1'b1;
         write_raw = 1'b1;   // flush IF/ID with a bubble
      end

      case (state_q)
         S_FETCH: begin
            if (misalign) begin
               if (redirect) begin
                  req_addr_d = align_addr(redirect_pc);
               end else begin
                  cap_exc = 1'b1;
                  pc_d    = cap_pc4;
                  state_d = S_HOLD;
               end
            end else if (imem_ack) begin
               if (redirect) begin
                  // returned word belongs to the abandoned path
                  req_addr_d = align_addr(redirect_pc);
               end else begin
                  cap_data = 1'b1;
                  pc_d     = cap_pc4;
                  state_d  = S_HOLD;
               end
            end else if (redirect) begin
               // request still owed an ack; keep address stable until it arrives
               state_d = S_DROP;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               req_addr_d = align_addr(redirect_pc);
               state_d    = S_FETCH;
            end else if (!stall) begin
               write_raw  = 1'b1;
               clr_valid  = 1'b1;
               req_addr_d = align_addr(pc_q);
               state_d    = S_FETCH;
            end
         end
         S_DROP: begin
            if (imem_ack) begin
               req_addr_d = align_addr(redirect ? redirect_pc : pc_q);
               state_d    = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: fetch controller plus the instruction buffer and
// IF/ID output muxing. Optional feature macro: IF_MISALIGN_EN.
module if_fetch
   import if_pkg::*;
#(
   parameter word_t RESET_PC  = DEF_RESET_PC,
   parameter word_t NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic  CLK,
   input  logic  RST,
   input  logic  stall,
   input  logic  redirect,
   input  word_t redirect_pc,
   output logic  imem_req,
   output word_t imem_addr,
   input  logic  imem_ack,
   input  word_t imem_rdata,
   output word_t IF_pc4,
   output word_t IF_IR,
   output logic  IF_write,
   output logic  IF_exc
);

   logic  cap_data, cap_exc, clr_valid;
   word_t cap_pc4;

   word_t buf_ir_q, buf_ir_d;
   word_t buf_pc4_q, buf_pc4_d;
   logic  buf_valid_q, buf_valid_d;
   logic  buf_exc_q, buf_exc_d;

   if_fetch_ctl #(
      .RESET_PC (RESET_PC)
   ) u_ctl (
      .CLK         (CLK),
      .RST         (RST),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_ack    (imem_ack),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .if_write    (IF_write),
      .cap_data    (cap_data),
      .cap_exc     (cap_exc),
      .clr_valid   (clr_valid),
      .cap_pc4     (cap_pc4)
   );

   // Buffer next-state: capture fetched word or exception bubble, clear on hand-off/flush
   always_comb begin
      buf_ir_d    = buf_ir_q;
      buf_pc4_d   = buf_pc4_q;
      buf_valid_d = buf_valid_q;
      buf_exc_d   = buf_exc_q;
      if (clr_valid) begin
         buf_valid_d = 1'b0;
      end
      if (cap_data) begin
         buf_ir_d    = imem_rdata;
         buf_pc4_d   = cap_pc4;
         buf_valid_d = 1'b1;
         buf_exc_d   = 1'b0;
      end
      if (cap_exc) begin
         buf_ir_d    = NOP_INSTR;
         buf_pc4_d   = cap_pc4;
         buf_valid_d = 1'b1;
         buf_exc_d   = 1'b1;
      end
   end

   // Buffer registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         buf_ir_q    <= NOP_INSTR;
         buf_pc4_q   <= 32'h0000_0000;
         buf_valid_q <= 1'b0;
         buf_exc_q   <= 1'b0;
      end else begin
         buf_ir_q    <= buf_ir_d;
         buf_pc4_q   <= buf_pc4_d;
         buf_valid_q <= buf_valid_d;
         buf_exc_q   <= buf_exc_d;
      end
   end

   // A redirect cycle or reset presents a bubble regardless of buffer contents.
   // Without IF_MISALIGN_EN buf_exc can never be set, so IF_exc stays 0.
   assign IF_IR  = (buf_valid_q && !redirect && !RST) ? buf_ir_q : NOP_INSTR;
   assign IF_pc4 = buf_pc4_q;
   assign IF_exc = buf_valid_q && buf_exc_q && !redirect && !RST;

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch. Inputs change 1 ns after the rising edge,
// outputs are sampled 1-2 ns later, well before the next edge.
`timescale 1ns/1ps
module tb_if_fetch;
   import if_pkg::*;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] IF_pc4;
   logic [31:0] IF_IR;
   logic        IF_write;
   logic        IF_exc;

   int n_cmp = 0;
   int n_err = 0;

   // clock
   always #5 CLK = ~CLK;

   if_fetch dut (
      .CLK         (CLK),
      .RST         (RST),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .IF_pc4      (IF_pc4),
      .IF_IR       (IF_IR),
      .IF_write    (IF_write),
      .IF_exc      (IF_exc)
   );

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF; stall = 1'b0;
      next_cycle(); #1;
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
      n_cmp++; if (IF_write !== 1'b0) begin n_err++; $display("FAIL rst_write: got %b want 0", IF_write); end
      n_cmp++; if (IF_IR !== 32'h0) begin n_err++; $display("FAIL rst_ir: got %h want 00000000", IF_IR); end
      n_cmp++; if (IF_exc !== 1'b0) begin n_err++; $display("FAIL rst_exc: got %b want 0", IF_exc); end
      next_cycle();
      RST = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; #1;
      n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rel_req: got %b want 1", imem_req); end
      n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rel_addr: got %h want 00000000", imem_addr); end
      n_cmp++; if (IF_pc4 !== 32'h0) begin n_err++; $display("FAIL rel_pc4: got %h want 00000000", IF_pc4); end
   endtask

   task automatic test_basic_fetch();
      next_cycle(); #1;
      n_cmp++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_err++; $display("FAIL basic_wait: got req %b addr %h want 1 00000000", imem_req, imem_addr); end
      next_cycle();
      imem_ack = 1'b1; imem_rdata = 32'h2008_0005; #1;
      n_cmp++; if (IF_write !== 1'b0) begin n_err++; $display("FAIL basic_ack_write: got %b want 0", IF_write); end
      next_cycle();
      imem_ack = 1'b0; imem_rdata = 32'h0; #1;
      n_cmp++; if (IF_IR !== 32'h2008_0005) begin n_err++; $display("FAIL basic_ir: got %h want 20080005", IF_IR); end
      n_cmp++; if (IF_pc4 !== 32'h4) begin n_err++; $display("FAIL basic_pc4: got %h want 00000004", IF_pc4); end
      n_cmp++; if (IF_write !== 1'b1) begin n_err++; $display("FAIL basic_write: got %b want 1", IF_write); end
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL basic_hold_req: got %b want 0", imem_req); end
      next_cycle(); #1;
      n_cmp++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin n_err++; $display("FAIL basic_next: got req %b addr %h want 1 00000004", imem_req, imem_addr); end
      n_cmp++; if (IF_write !== 1'b0) begin n_err++; $display("FAIL basic_write_once: got %b want 0", IF_write); end
      n_cmp++; if (IF_IR !== 32'h0) begin n_err++; $display("FAIL basic_bubble: got %h want 00000000", IF_IR); end
   endtask

   task automatic test_stall();
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
      next_cycle();
      imem_ack = 1'b0; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (IF_write !== 1'b0) begin n_err++; $display("FAIL stall_write[%0d]: got %b want 0", i, IF_write); end
         n_cmp++; if (IF_IR !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL stall_ir[%0d]: got %h want deadbeef", i, IF_IR); end
         n_cmp++; if (IF_pc4 !== 32'h8) begin n_err++; $display("FAIL stall_pc4[%0d]: got %h want 00000008", i, IF_pc4); end
         n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req[%0d]: got %b want 0", i, imem_req); end
         next_cycle();
      end
      stall = 1'b0; #1;
      n_cmp++; if (IF_write !== 1'b1 || IF_IR !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL stall_release: got write %b ir %h want 1 deadbeef", IF_write, IF_IR); end
      next_cycle(); #1;
      n_cmp++; if (imem_addr !== 32'h8 || IF_write !== 1'b0) begin n_err++; $display("FAIL stall_next: got addr %h write %b want 00000008 0", imem_addr, IF_write); end
   endtask

   task automatic test_redirect_drop();
      // redirect coincident with ack: go straight to 0x10
      redirect = 1'b1; redirect_pc = 32'h10; imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA; #1;
      n_cmp++; if (IF_write !== 1'b1 || IF_IR !== 32'h0) begin n_err++; $display("FAIL redir_ack_flush: got write %b ir %h want 1 00000000", IF_write, IF_IR); end
      next_cycle();
      redirect = 1'b0; imem_ack = 1'b0; #1;
      n_cmp++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin n_err++; $display("FAIL redir_ack_addr: got req %b addr %h want 1 00000010", imem_req, imem_addr); end
      // redirect while request to 0x10 still outstanding
      redirect = 1'b1; redirect_pc = 32'h40; #1;
      n_cmp++; if (IF_write !== 1'b1) begin n_err++; $display("FAIL drop_flush: got %b want 1", IF_write); end
      next_cycle();
      redirect = 1'b0; #1;
      n_cmp++; if (dut.u_ctl.state_q !== S_DROP) begin n_err++; $display("FAIL drop_state: got %0d want %0d", dut.u_ctl.state_q, S_DROP); end
      n_cmp++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin n_err++; $display("FAIL drop_req: got req %b addr %h want 1 00000010", imem_req, imem_addr); end
      next_cycle();
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD; #1;
      n_cmp++; if (IF_write !== 1'b0 || imem_addr !== 32'h10) begin n_err++; $display("FAIL drop_ack: got write %b addr %h want 0 00000010", IF_write, imem_addr); end
      next_cycle();
      imem_ack = 1'b0; #1;
      n_cmp++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin n_err++; $display("FAIL drop_next: got req %b addr %h want 1 00000040", imem_req, imem_addr); end
      n_cmp++; if (IF_IR !== 32'h0 || IF_write !== 1'b0) begin n_err++; $display("FAIL drop_discard: got ir %h write %b want 00000000 0", IF_IR, IF_write); end
   endtask

   task automatic test_redirect_stall();
      imem_ack = 1'b1; imem_rdata = 32'h7777_0000; redirect = 1'b1; redirect_pc = 32'h80; stall = 1'b1; #1;
      n_cmp++; if (IF_write !== 1'b1 || IF_IR !== 32'h0) begin n_err++; $display("FAIL rs_fetch_flush: got write %b ir %h want 1 00000000", IF_write, IF_IR); end
      next_cycle();
      imem_ack = 1'b0; redirect = 1'b0; stall = 1'b0; #1;
      n_cmp++; if (imem_addr !== 32'h80 || imem_req !== 1'b1) begin n_err++; $display("FAIL rs_fetch_next: got req %b addr %h want 1 00000080", imem_req, imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
      next_cycle();
      imem_ack = 1'b0; stall = 1'b1; #1;
      n_cmp++; if (IF_IR !== 32'h1111_2222 || IF_write !== 1'b0) begin n_err++; $display("FAIL rs_hold: got ir %h write %b want 11112222 0", IF_IR, IF_write); end
      redirect = 1'b1; redirect_pc = 32'h100; #1;
      n_cmp++; if (IF_write !== 1'b1 || IF_IR !== 32'h0 || IF_exc !== 1'b0) begin n_err++; $display("FAIL rs_hold_flush: got write %b ir %h exc %b want 1 00000000 0", IF_write, IF_IR, IF_exc); end
      next_cycle();
      redirect = 1'b0; stall = 1'b0; #1;
      n_cmp++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin n_err++; $display("FAIL rs_hold_next: got req %b addr %h want 1 00000100", imem_req, imem_addr); end
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ack = 1'b1; imem_rdata = 32'h0123_4567; #1;
      next_cycle();
      redirect = 1'b0; imem_ack = 1'b0; #1;
      n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'h3333_4444;
      next_cycle();
      imem_ack = 1'b0; #1;
      n_cmp++; if (IF_pc4 !== 32'h0 || IF_IR !== 32'h3333_4444) begin n_err++; $display("FAIL wrap_pc4: got pc4 %h ir %h want 00000000 33334444", IF_pc4, IF_IR); end
      next_cycle(); #1;
      n_cmp++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_err++; $display("FAIL wrap_next: got req %b addr %h want 1 00000000", imem_req, imem_addr); end
   endtask

   task automatic test_misalign();
      redirect = 1'b1; redirect_pc = 32'h42; imem_ack = 1'b1; imem_rdata = 32'h9999_9999; #1;
      next_cycle();
      redirect = 1'b0; imem_ack = 1'b0; #1;
`ifdef IF_MISALIGN_EN
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL mis_req: got %b want 0", imem_req); end
      next_cycle(); #1;
      n_cmp++; if (IF_exc !== 1'b1 || IF_IR !== 32'h0) begin n_err++; $display("FAIL mis_exc: got exc %b ir %h want 1 00000000", IF_exc, IF_IR); end
      n_cmp++; if (IF_write !== 1'b1) begin n_err++; $display("FAIL mis_write: got %b want 1", IF_write); end
`else
      n_cmp++; if (imem_addr !== 32'h40 || imem_req !== 1'b1 || IF_exc !== 1'b0) begin n_err++; $display("FAIL mis_align: got req %b addr %h exc %b want 1 00000040 0", imem_req, imem_addr, IF_exc); end
      imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
      next_cycle();
      imem_ack = 1'b0; #1;
      n_cmp++; if (IF_IR !== 32'hCAFE_F00D || IF_pc4 !== 32'h44 || IF_exc !== 1'b0) begin n_err++; $display("FAIL mis_fetch: got ir %h pc4 %h exc %b want cafef00d 00000044 0", IF_IR, IF_pc4, IF_exc); end
`endif
   endtask

   task automatic test_reset_mid();
      // a valid instruction is held here; reset must mask it immediately
      stall = 1'b0; RST = 1'b1; imem_ack = 1'b1; #1;
      n_cmp++; if (IF_IR !== 32'h0 || IF_write !== 1'b0 || IF_exc !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL midrst_out: got ir %h write %b exc %b req %b want 00000000 0 0 0", IF_IR, IF_write, IF_exc, imem_req); end
      next_cycle();
      RST = 1'b0; imem_ack = 1'b0; #1;
      n_cmp++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_err++; $display("FAIL midrst_addr: got req %b addr %h want 1 00000000", imem_req, imem_addr); end
      n_cmp++; if (IF_pc4 !== 32'h0 || IF_IR !== 32'h0) begin n_err++; $display("FAIL midrst_buf: got pc4 %h ir %h want 00000000 00000000", IF_pc4, IF_IR); end
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_stall();
      test_redirect_drop();
      test_redirect_stall();
      test_wrap();
      test_misalign();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
